// File: rtl/decode_stage.sv
// RV32I subset decode stage: instruction decode, 32x32 register file with write-through
// read bypass, branch/jump resolution in D, and the ID/EX pipeline register.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    input  logic [31:0] ALUResultM,
    input  logic        ForwardAD,
    input  logic        ForwardBD,
    input  logic        FlushE,
    output logic [31:0] PCBranchD,
    output logic        BranchD,
    output logic        PCSrcD,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        ALUSrcE,
    output logic [1:0]  ResultSrcE,
    output logic [3:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  RdE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] ins);
        return {ins[31:12], 12'd0};
    endfunction

    // Returns {legal, alu_op}; for immediates only the shift encodings constrain funct7.
    function automatic logic [4:0] alu_decode(input logic [2:0] f3, input logic [6:0] f7,
                                              input logic is_imm);
        logic f7_zero;
        logic f7_alt;
        logic [4:0] res;
        f7_zero = (f7 == 7'b0000000);
        f7_alt  = (f7 == 7'b0100000);
        case (f3)
            3'b000: begin
                if (is_imm || f7_zero) res = {1'b1, ALU_ADD};
                else if (f7_alt)       res = {1'b1, ALU_SUB};
                else                   res = {1'b0, ALU_ADD};
            end
            3'b001:  res = f7_zero ? {1'b1, ALU_SLL} : {1'b0, ALU_ADD};
            3'b010:  res = (is_imm || f7_zero) ? {1'b1, ALU_SLT}  : {1'b0, ALU_ADD};
            3'b011:  res = (is_imm || f7_zero) ? {1'b1, ALU_SLTU} : {1'b0, ALU_ADD};
            3'b100:  res = (is_imm || f7_zero) ? {1'b1, ALU_XOR}  : {1'b0, ALU_ADD};
            3'b110:  res = (is_imm || f7_zero) ? {1'b1, ALU_OR}   : {1'b0, ALU_ADD};
            3'b111:  res = (is_imm || f7_zero) ? {1'b1, ALU_AND}  : {1'b0, ALU_ADD};
            3'b101: begin
                if (f7_zero)     res = {1'b1, ALU_SRL};
                else if (f7_alt) res = {1'b1, ALU_SRA};
                else             res = {1'b0, ALU_ADD};
            end
            default: res = {1'b0, ALU_ADD};
        endcase
        return res;
    endfunction

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [4:0]  rd_s;

    assign opcode_s = InstrD[6:0];
    assign funct3_s = InstrD[14:12];
    assign funct7_s = InstrD[31:25];
    assign rs1_s    = InstrD[19:15];
    assign rs2_s    = InstrD[24:20];
    assign rd_s     = InstrD[11:7];
    assign Rs1D     = rs1_s;
    assign Rs2D     = rs2_s;

    logic [31:0] rf_q [32];
    logic [31:0] rd1_s;
    logic [31:0] rd2_s;

    // Register file storage; reset clears every entry and wins over a pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (RegWriteW && (RdW != 5'd0)) begin
            rf_q[RdW] <= ResultW;
        end
    end

    // Read ports with write-through bypass so W-stage results are visible in the same cycle.
    always_comb begin
        rd1_s = 32'd0;
        rd2_s = 32'd0;
        if (rs1_s == 5'd0) begin
            rd1_s = 32'd0;
        end else if (RegWriteW && (RdW == rs1_s)) begin
            rd1_s = ResultW;
        end else begin
            rd1_s = rf_q[rs1_s];
        end
        if (rs2_s == 5'd0) begin
            rd2_s = 32'd0;
        end else if (RegWriteW && (RdW == rs2_s)) begin
            rd2_s = ResultW;
        end else begin
            rd2_s = rf_q[rs2_s];
        end
    end

    logic        legal_s;
    logic        reg_write_s;
    logic        mem_write_s;
    logic        alu_src_s;
    logic [1:0]  result_src_s;
    logic [3:0]  alu_ctrl_s;
    logic        branch_s;
    logic        jump_s;
    logic        bne_s;
    logic        lui_s;
    logic [31:0] imm_ext_s;
    logic [4:0]  alu_dec_s;

    // Main opcode decode; raw controls are gated by legal_s further down.
    always_comb begin
        legal_s      = 1'b0;
        reg_write_s  = 1'b0;
        mem_write_s  = 1'b0;
        alu_src_s    = 1'b0;
        result_src_s = RES_ALU;
        alu_ctrl_s   = ALU_ADD;
        branch_s     = 1'b0;
        jump_s       = 1'b0;
        bne_s        = 1'b0;
        lui_s        = 1'b0;
        imm_ext_s    = imm_i(InstrD);
        alu_dec_s    = 5'd0;
        case (opcode_s)
            OP_RTYPE: begin
                alu_dec_s   = alu_decode(funct3_s, funct7_s, 1'b0);
                legal_s     = alu_dec_s[4];
                reg_write_s = 1'b1;
                alu_ctrl_s  = alu_dec_s[3:0];
            end
            OP_ITYPE: begin
                alu_dec_s   = alu_decode(funct3_s, funct7_s, 1'b1);
                legal_s     = alu_dec_s[4];
                reg_write_s = 1'b1;
                alu_src_s   = 1'b1;
                alu_ctrl_s  = alu_dec_s[3:0];
            end
            OP_LOAD: begin
                legal_s      = (funct3_s == 3'b010);
                reg_write_s  = 1'b1;
                alu_src_s    = 1'b1;
                result_src_s = RES_MEM;
            end
            OP_STORE: begin
                legal_s     = (funct3_s == 3'b010);
                mem_write_s = 1'b1;
                alu_src_s   = 1'b1;
                imm_ext_s   = imm_s(InstrD);
            end
            OP_BRANCH: begin
                legal_s    = (funct3_s == 3'b000) || (funct3_s == 3'b001);
                branch_s   = 1'b1;
                bne_s      = funct3_s[0];
                alu_ctrl_s = ALU_SUB;
                imm_ext_s  = imm_b(InstrD);
            end
            OP_JAL: begin
                legal_s      = 1'b1;
                jump_s       = 1'b1;
                reg_write_s  = 1'b1;
                result_src_s = RES_PC4;
                imm_ext_s    = imm_j(InstrD);
            end
            OP_LUI: begin
                legal_s     = 1'b1;
                reg_write_s = 1'b1;
                alu_src_s   = 1'b1;
                lui_s       = 1'b1;
                imm_ext_s   = imm_u(InstrD);
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    logic [31:0] cmp_a_s;
    logic [31:0] cmp_b_s;
    logic        equal_s;

    assign cmp_a_s   = ForwardAD ? ALUResultM : rd1_s;
    assign cmp_b_s   = ForwardBD ? ALUResultM : rd2_s;
    assign equal_s   = (cmp_a_s == cmp_b_s);
    assign PCBranchD = (PCPlus4D - 32'd4) + imm_ext_s;

    // Branch/jump resolution; an illegal encoding never redirects fetch.
    always_comb begin
        BranchD = 1'b0;
        PCSrcD  = 1'b0;
        if (legal_s) begin
            BranchD = branch_s;
            PCSrcD  = (branch_s && (bne_s ? !equal_s : equal_s)) || jump_s;
        end else begin
            BranchD = 1'b0;
            PCSrcD  = 1'b0;
        end
    end

    logic        reg_write_d,  reg_write_q;
    logic        mem_write_d,  mem_write_q;
    logic        alu_src_d,    alu_src_q;
    logic [1:0]  result_src_d, result_src_q;
    logic [3:0]  alu_ctrl_d,   alu_ctrl_q;
    logic [31:0] rd1_d,        rd1_q;
    logic [31:0] rd2_d,        rd2_q;
    logic [31:0] imm_d,        imm_q;
    logic [31:0] pc4_d,        pc4_q;
    logic [4:0]  rd_d,         rd_q;
    logic [4:0]  rs1_d,        rs1_q;
    logic [4:0]  rs2_d,        rs2_q;

    // ID/EX next state: illegal encodings become a bubble on controls only, data fields pass.
    always_comb begin
        reg_write_d  = 1'b0;
        mem_write_d  = 1'b0;
        alu_src_d    = 1'b0;
        result_src_d = RES_ALU;
        alu_ctrl_d   = ALU_ADD;
        if (legal_s) begin
            reg_write_d  = reg_write_s;
            mem_write_d  = mem_write_s;
            alu_src_d    = alu_src_s;
            result_src_d = result_src_s;
            alu_ctrl_d   = alu_ctrl_s;
        end else begin
            reg_write_d  = 1'b0;
            mem_write_d  = 1'b0;
            alu_src_d    = 1'b0;
            result_src_d = RES_ALU;
            alu_ctrl_d   = ALU_ADD;
        end
        rd1_d = (legal_s && lui_s) ? 32'd0 : rd1_s;
        rd2_d = rd2_s;
        imm_d = imm_ext_s;
        pc4_d = PCPlus4D;
        rd_d  = rd_s;
        rs1_d = rs1_s;
        rs2_d = rs2_s;
    end

    // ID/EX register; reset and flush both load an all-zero bubble.
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            result_src_q <= 2'b00;
            alu_ctrl_q   <= 4'd0;
            rd1_q        <= 32'd0;
            rd2_q        <= 32'd0;
            imm_q        <= 32'd0;
            pc4_q        <= 32'd0;
            rd_q         <= 5'd0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            alu_src_q    <= alu_src_d;
            result_src_q <= result_src_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            pc4_q        <= pc4_d;
            rd_q         <= rd_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
        end
    end

    assign RegWriteE   = reg_write_q;
    assign MemWriteE   = mem_write_q;
    assign ALUSrcE     = alu_src_q;
    assign ResultSrcE  = result_src_q;
    assign ALUControlE = alu_ctrl_q;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign ImmExtE     = imm_q;
    assign PCPlus4E    = pc4_q;
    assign RdE         = rd_q;
    assign Rs1E        = rs1_q;
    assign Rs2E        = rs2_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: hand-encoded instructions with hand-computed results.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [31:0] ALUResultM;
    logic        ForwardAD;
    logic        ForwardBD;
    logic        FlushE;
    logic [31:0] PCBranchD;
    logic        BranchD;
    logic        PCSrcD;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [31:0] PCPlus4E;
    logic [4:0]  RdE;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;

    int n_tests = 0;
    int n_fail  = 0;

    decode_stage dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .ALUResultM(ALUResultM),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .FlushE(FlushE),
        .PCBranchD(PCBranchD), .BranchD(BranchD), .PCSrcD(PCSrcD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
        .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
        RegWriteW = en;
        RdW       = rd;
        ResultW   = data;
    endtask

    initial begin
        reset = 1'b1; InstrD = 32'd0; PCPlus4D = 32'd0; ALUResultM = 32'd0;
        ForwardAD = 1'b0; ForwardBD = 1'b0; FlushE = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        tick;
        tick;
        check("rst_regwriteE", 32'(RegWriteE), 32'd0);
        check("rst_rd1E", RD1E, 32'd0);
        check("rst_immE", ImmExtE, 32'd0);
        check("rst_pc4E", PCPlus4E, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_pcsrcD", 32'(PCSrcD), 32'd0);
        check("rst_pcbranchD", PCBranchD, 32'hFFFF_FFFC);

        // write x5 then addi x6,x5,1
        wb(1'b1, 5'd5, 32'h0000_1234);
        tick;
        wb(1'b0, 5'd0, 32'd0);
        InstrD = enc_i(12'd1, 5'd5, 3'b000, 5'd6);
        PCPlus4D = 32'h0000_0020;
        tick;
        check("addi_rd1E", RD1E, 32'h0000_1234);
        check("addi_immE", ImmExtE, 32'd1);
        check("addi_aluctlE", 32'(ALUControlE), 32'd0);
        check("addi_alusrcE", 32'(ALUSrcE), 32'd1);
        check("addi_regwriteE", 32'(RegWriteE), 32'd1);
        check("addi_rdE", 32'(RdE), 32'd6);
        check("addi_rs1E", 32'(Rs1E), 32'd5);
        check("addi_pc4E", PCPlus4E, 32'h0000_0020);

        // same-cycle bypass of x3, then write to x0 is ignored
        wb(1'b1, 5'd3, 32'h0000_00AA);
        InstrD = enc_r(7'd0, 5'd0, 5'd3, 3'b000, 5'd1);
        #1;
        check("add_rs1D", 32'(Rs1D), 32'd3);
        tick;
        check("bypass_rd1E", RD1E, 32'h0000_00AA);
        check("bypass_rd2E", RD2E, 32'd0);
        check("add_alusrcE", 32'(ALUSrcE), 32'd0);
        wb(1'b1, 5'd0, 32'h0000_DEAD);
        InstrD = enc_r(7'd0, 5'd3, 5'd0, 3'b000, 5'd1);
        tick;
        check("x0_bypass_rd1E", RD1E, 32'd0);
        check("x3_stored_rd2E", RD2E, 32'h0000_00AA);
        wb(1'b0, 5'd0, 32'd0);
        InstrD = enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd1);
        tick;
        check("x0_stays_zero", RD1E, 32'd0);
        InstrD = enc_r(7'b0100000, 5'd3, 5'd3, 3'b000, 5'd2);
        tick;
        check("sub_aluctlE", 32'(ALUControlE), 32'd1);

        // beq/bne with x1 == x2
        wb(1'b1, 5'd1, 32'h0000_0055);
        tick;
        wb(1'b1, 5'd2, 32'h0000_0055);
        tick;
        wb(1'b0, 5'd0, 32'd0);
        InstrD = enc_b(13'h1FF8, 5'd2, 5'd1, 3'b000);
        PCPlus4D = 32'h0000_0104;
        #1;
        check("beq_pcsrcD", 32'(PCSrcD), 32'd1);
        check("beq_branchD", 32'(BranchD), 32'd1);
        check("beq_pcbranchD", PCBranchD, 32'h0000_00F8);
        InstrD = enc_b(13'h1FF8, 5'd2, 5'd1, 3'b001);
        #1;
        check("bne_eq_pcsrcD", 32'(PCSrcD), 32'd0);
        check("bne_branchD", 32'(BranchD), 32'd1);
        ForwardBD = 1'b1;
        ALUResultM = 32'd9;
        #1;
        check("bne_fwdB_pcsrcD", 32'(PCSrcD), 32'd1);
        ForwardBD = 1'b0;
        tick;

        // jal x1,+0x20
        InstrD = enc_j(21'h00020, 5'd1);
        PCPlus4D = 32'h0000_0010;
        #1;
        check("jal_pcsrcD", 32'(PCSrcD), 32'd1);
        check("jal_branchD", 32'(BranchD), 32'd0);
        check("jal_pcbranchD", PCBranchD, 32'h0000_002C);
        tick;
        check("jal_resultsrcE", 32'(ResultSrcE), 32'd2);
        check("jal_pc4E", PCPlus4E, 32'h0000_0010);
        check("jal_regwriteE", 32'(RegWriteE), 32'd1);
        check("jal_immE", ImmExtE, 32'h0000_0020);

        // forwarded branch compare: x1=0x55, x2=7, ALUResultM=7
        wb(1'b1, 5'd2, 32'd7);
        tick;
        wb(1'b0, 5'd0, 32'd0);
        InstrD = enc_b(13'd16, 5'd2, 5'd1, 3'b000);
        PCPlus4D = 32'h0000_0040;
        ALUResultM = 32'd7;
        #1;
        check("beq_nofwd_pcsrcD", 32'(PCSrcD), 32'd0);
        ForwardAD = 1'b1;
        #1;
        check("beq_fwdA_pcsrcD", 32'(PCSrcD), 32'd1);
        check("beq_fwdA_pcbranchD", PCBranchD, 32'h0000_004C);
        ForwardAD = 1'b0;

        // sw: normal, then flushed while a writeback still lands
        InstrD = enc_s(12'd4, 5'd2, 5'd1);
        tick;
        check("sw_memwriteE", 32'(MemWriteE), 32'd1);
        check("sw_immE", ImmExtE, 32'd4);
        check("sw_regwriteE", 32'(RegWriteE), 32'd0);
        FlushE = 1'b1;
        wb(1'b1, 5'd7, 32'h0000_0077);
        tick;
        check("flush_memwriteE", 32'(MemWriteE), 32'd0);
        check("flush_immE", ImmExtE, 32'd0);
        check("flush_rd1E", RD1E, 32'd0);
        FlushE = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        InstrD = enc_r(7'd0, 5'd0, 5'd7, 3'b000, 5'd8);
        tick;
        check("flush_wb_kept", RD1E, 32'h0000_0077);

        // srai, lui, unsupported encodings
        InstrD = enc_i(12'h402, 5'd1, 3'b101, 5'd3);
        tick;
        check("srai_aluctlE", 32'(ALUControlE), 32'd8);
        check("srai_immE", ImmExtE, 32'h0000_0402);
        InstrD = {20'hABC08, 5'd4, 7'b0110111};
        tick;
        check("lui_immE", ImmExtE, 32'hABC0_8000);
        check("lui_rd1E", RD1E, 32'd0);
        check("lui_rs1E", 32'(Rs1E), 32'd1);
        check("lui_alusrcE", 32'(ALUSrcE), 32'd1);
        check("lui_regwriteE", 32'(RegWriteE), 32'd1);
        InstrD = 32'h0000_00FF;
        #1;
        check("bad_op_pcsrcD", 32'(PCSrcD), 32'd0);
        tick;
        check("bad_op_regwriteE", 32'(RegWriteE), 32'd0);
        InstrD = enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd5);
        tick;
        check("bad_f7_regwriteE", 32'(RegWriteE), 32'd0);
        check("bad_f7_rd1E", RD1E, 32'h0000_0055);

        // reset mid-stream with a writeback pending
        InstrD = enc_i(12'd1, 5'd1, 3'b000, 5'd5);
        wb(1'b1, 5'd9, 32'h0000_0099);
        reset = 1'b1;
        tick;
        check("midrst_regwriteE", 32'(RegWriteE), 32'd0);
        check("midrst_rd1E", RD1E, 32'd0);
        check("midrst_immE", ImmExtE, 32'd0);
        check("midrst_pc4E", PCPlus4E, 32'd0);
        check("midrst_rdE", 32'(RdE), 32'd0);
        reset = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        InstrD = enc_r(7'd0, 5'd1, 5'd9, 3'b000, 5'd10);
        tick;
        check("midrst_x9_zero", RD1E, 32'd0);
        check("midrst_x1_zero", RD2E, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 One clock; reset is synchronous and active-high, named clk and reset.
REQ-002 clk  in  1  rising-edge clock for register file and ID/EX register.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 InstrD  in  32  instruction from IF/ID register.
REQ-005 PCPlus4D  in  32  PC+4 of InstrD.
REQ-006 RegWriteW  in  1  writeback enable.
REQ-007 RdW  in  5  writeback destination.
REQ-008 ResultW  in  32  writeback data.
REQ-009 ALUResultM  in  32  Mem-stage ALU result, forwarding source.
REQ-010 ForwardAD / ForwardBD  in  1 each  select ALUResultM for branch-compare operand rs1 / rs2.
REQ-011 FlushE  in  1  load bubble into ID/EX at next edge.
REQ-012 PCBranchD  out  32  branch/jump target to fetch.
REQ-013 BranchD  out  1  InstrD is a conditional branch (beq/bne).
REQ-014 PCSrcD  out  1  redirect fetch to PCBranchD.
REQ-015 Rs1D / Rs2D  out  5 each  InstrD[19:15] / InstrD[24:20], to hazard unit.
REQ-016 RegWriteE, MemWriteE, ALUSrcE  out  1 each  registered controls.
REQ-017 ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4.
REQ-018 ALUControlE  out  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLL,7 SRL,8 SRA,9 SLTU.
REQ-019 RD1E, RD2E, ImmExtE, PCPlus4E  out  32 each  registered operands/immediate/PC+4.
REQ-020 RdE, Rs1E, Rs2E  out  5 each  registered register indices.

Function
REQ-021 Supported: R-type ALU (0110011), I-type ALU (0010011), lw (0000011), sw (0100011), beq/bne (1100011), jal (1101111), lui (0110111).
REQ-022 Immediates sign-extended from bit 31: I, S, B (bit0=0), J (bit0=0); U = {InstrD[31:12],12'b0}.
REQ-023 Register file: 32x32, synchronous write at rising clk when RegWriteW=1 and RdW!=0; x0 reads 0 always.
REQ-024 Read bypass: if RegWriteW=1, RdW!=0 and RdW equals read index, read port returns ResultW same cycle.
REQ-025 Branch compare operands: ForwardXD=1 ? ALUResultM : register-file read (post-bypass).
REQ-026 PCBranchD = (PCPlus4D - 4) + ImmExt, modulo 2^32; combinational.
REQ-027 PCSrcD = (beq & equal) | (bne & !equal) | jal; BranchD=0 for jal.
REQ-028 lui: ALUSrc=1, RD1 forced 0, ADD; jal: RegWrite=1, ResultSrc=10.
REQ-029 I-type shifts use InstrD[30] for SRL/SRA; R-type InstrD[30] selects SUB/SRA.
REQ-030 Unsupported opcode/funct: RegWrite=0, MemWrite=0, PCSrcD=0, all else 0 (bubble).
REQ-031 ID/EX register: captures all E outputs every rising clk; no stall input.
REQ-032 FlushE=1: next edge loads all E outputs as 0, register file write still occurs.
REQ-033 ImmExt, RD1/RD2, Rs1/Rs2/Rd latched unchanged for bubbles only when not flushed.

Reset
REQ-034 reset=1 at edge: all ID/EX outputs 0, all 32 registers 0; reset dominates FlushE and RegWriteW.
REQ-035 D-stage combinational outputs depend only on inputs and register contents; after reset PCSrcD=0 for InstrD=0.

Verification
REQ-036 Write x5=0x1234 via RdW/ResultW, next cycle addi x6,x5,1 -> RD1E=0x1234, ImmExtE=1, ALUControlE=0, ALUSrcE=1.
REQ-037 RegWriteW=1,RdW=3,ResultW=0xAA same cycle as add x1,x3,x0 -> RD1E=0xAA (bypass); RdW=0 write -> x0 stays 0.
REQ-038 beq x1,x2,-8 at PCPlus4D=0x104, x1=x2 -> PCSrcD=1, BranchD=1, PCBranchD=0xF8; bne same -> PCSrcD=0.
REQ-039 jal x1,+0x20 at PCPlus4D=0x10 -> PCSrcD=1, BranchD=0, PCBranchD=0x2C; next edge ResultSrcE=10, PCPlus4E=0x10.
REQ-040 ForwardAD=1, ALUResultM=7, x2=7, beq -> PCSrcD=1; FlushE=1 with sw -> next MemWriteE=0.
REQ-041 reset asserted mid-stream with RegWriteW=1 -> all E outputs 0, register written value reads 0 after.
